// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one instruction-bus request
// in flight and hands fetched words to decode over a valid/ready handshake.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [95:0] out_data,
  input  logic        out_ready,
  output logic [63:0] fetch_count
);

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HOLD
  } state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [63:0] pend_pc, pend_pc_next;
  fetch_data_t out_reg, out_reg_next;
  logic [63:0] count, count_next;
  logic        fire;

  assign ireq_addr   = pc;
  assign ireq_valid  = (state == REQ) || (state == DISCARD);
  assign out_valid   = (state == HOLD) && !redirect_valid;
  assign fire        = out_valid && out_ready;
  assign out_data    = out_reg;
  assign fetch_count = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= '0;
      out_reg <= '0;
      count   <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
      out_reg <= out_reg_next;
      count   <= count_next;
    end
  end

  // The bus cannot cancel a request, so a redirect without a same-cycle
  // response parks the target in pend_pc and waits out the stale reply.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    out_reg_next = out_reg;
    count_next   = count;
    unique case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (iresp_data_ok && redirect_valid) begin
          pc_next = redirect_pc;
        end else if (iresp_data_ok) begin
          out_reg_next.raw_instr = iresp_data;
          out_reg_next.pc        = pc;
          state_next             = HOLD;
        end else if (redirect_valid) begin
          pend_pc_next = redirect_pc;
          state_next   = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          pend_pc_next = redirect_pc;
        end
        if (iresp_data_ok) begin
          pc_next    = redirect_valid ? redirect_pc : pend_pc;
          state_next = REQ;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = REQ;
        end else if (fire) begin
          pc_next    = pc + 64'd4;
          count_next = count + 64'd1;
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector tables for the corner
// cases, then a randomized run against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [95:0] out_data;
  logic        out_ready;
  logic [63:0] fetch_count;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic        ok;
    logic [31:0] data;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [95:0] e_od;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [95:0] actual,
                              input logic [95:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ok, input logic [31:0] data,
                                input logic rv, input logic [63:0] rpc,
                                input logic rdy);
    iresp_data_ok  = ok;
    iresp_data     = data;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  // One cycle: drive inputs just after the falling edge, check, then advance.
  task automatic run_vec(input string name, input vec_t v);
    apply_stimulus(v.ok, v.data, v.rv, v.rpc, v.rdy);
    check_output({name, ".ireq_valid"}, 96'(ireq_valid), 96'(v.e_iv));
    check_output({name, ".ireq_addr"}, 96'(ireq_addr), 96'(v.e_addr));
    check_output({name, ".out_valid"}, 96'(out_valid), 96'(v.e_ov));
    check_output({name, ".fetch_count"}, 96'(fetch_count), 96'(v.e_cnt));
    if (v.e_ov) check_output({name, ".out_data"}, out_data, v.e_od);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    repeat (2) @(negedge clk);
    check_output("rst.ireq_valid", 96'(ireq_valid), 96'(0));
    check_output("rst.ireq_addr", 96'(ireq_addr), 96'(RESET_PC));
    check_output("rst.out_valid", 96'(out_valid), 96'(0));
    check_output("rst.fetch_count", 96'(fetch_count), 96'(0));
    check_output("rst.out_data", out_data, 96'(0));
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic ok, input logic [31:0] data,
                              input logic rv, input logic [63:0] rpc,
                              input logic rdy, input logic e_iv,
                              input logic [63:0] e_addr, input logic e_ov,
                              input logic [95:0] e_od, input logic [63:0] e_cnt);
    vec_t v;
    v = '{ok, data, rv, rpc, rdy, e_iv, e_addr, e_ov, e_od, e_cnt};
    return v;
  endfunction

  function automatic logic [31:0] bus_word(input logic [63:0] addr);
    return addr[31:0] ^ addr[63:32] ^ 32'hA5A5_0013;
  endfunction

  initial begin
    logic [63:0] wrap_pc;
    tests_run    = 0;
    tests_failed = 0;
    wrap_pc      = 64'hFFFF_FFFF_FFFF_FFFC;

    // Zero-wait bus, first fetch, backpressure, redirect in HOLD with ready.
    vecs[0]  = mk(0, 32'h0, 0, 0, 1, 0, 64'h8000_0000, 0, 96'h0, 0);
    vecs[1]  = mk(1, 32'h13, 0, 0, 1, 1, 64'h8000_0000, 0, 96'h0, 0);
    vecs[2]  = mk(0, 32'h0, 0, 0, 1, 0, 64'h8000_0000, 1,
                  {32'h13, 64'h8000_0000}, 0);
    vecs[3]  = mk(1, 32'h0010_0093, 0, 0, 0, 1, 64'h8000_0004, 0, 96'h0, 1);
    for (int i = 4; i <= 8; i++)
      vecs[i] = mk(0, 32'h0, 0, 0, 0, 0, 64'h8000_0004, 1,
                   {32'h0010_0093, 64'h8000_0004}, 1);
    vecs[9]  = mk(0, 32'h0, 0, 0, 1, 0, 64'h8000_0004, 1,
                  {32'h0010_0093, 64'h8000_0004}, 1);
    vecs[10] = mk(1, 32'h11, 0, 0, 1, 1, 64'h8000_0008, 0, 96'h0, 2);
    vecs[11] = mk(0, 32'h0, 1, 64'h8000_0040, 1, 0, 64'h8000_0008, 0, 96'h0, 2);
    vecs[12] = mk(0, 32'h0, 0, 0, 1, 1, 64'h8000_0040, 0, 96'h0, 2);
    vecs[13] = mk(1, 32'h22, 0, 0, 1, 1, 64'h8000_0040, 0, 96'h0, 2);
    vecs[14] = mk(0, 32'h0, 0, 0, 1, 0, 64'h8000_0040, 1,
                  {32'h22, 64'h8000_0040}, 2);
    vecs[15] = mk(0, 32'h0, 0, 0, 0, 1, 64'h8000_0044, 0, 96'h0, 3);

    do_reset();
    for (int i = 0; i < 16; i++) run_vec($sformatf("tbl%0d", i), vecs[i]);

    // Redirect while waiting on a 3-cycle bus, then a double redirect in DISCARD.
    do_reset();
    run_vec("wait.idle", mk(0, 0, 0, 0, 0, 0, 64'h8000_0000, 0, 0, 0));
    run_vec("wait.c1", mk(0, 0, 1, 64'h8000_0100, 0, 1, 64'h8000_0000, 0, 0, 0));
    run_vec("wait.c2", mk(0, 0, 0, 0, 0, 1, 64'h8000_0000, 0, 0, 0));
    run_vec("wait.c3", mk(1, 32'hDEAD_BEEF, 0, 0, 0, 1, 64'h8000_0000, 0, 0, 0));
    run_vec("wait.c4", mk(0, 0, 0, 0, 0, 1, 64'h8000_0100, 0, 0, 0));
    run_vec("wait.c5", mk(1, 32'h55, 0, 0, 0, 1, 64'h8000_0100, 0, 0, 0));
    run_vec("wait.c6", mk(0, 0, 0, 0, 1, 0, 64'h8000_0100, 1,
                          {32'h55, 64'h8000_0100}, 0));
    run_vec("dbl.c1", mk(0, 0, 1, 64'h100, 0, 1, 64'h8000_0104, 0, 0, 1));
    run_vec("dbl.c2", mk(0, 0, 1, 64'h200, 0, 1, 64'h8000_0104, 0, 0, 1));
    run_vec("dbl.c3", mk(1, 32'hBAD0, 0, 0, 0, 1, 64'h8000_0104, 0, 0, 1));
    run_vec("dbl.c4", mk(1, 32'h77, 0, 0, 0, 1, 64'h200, 0, 0, 1));
    run_vec("dbl.c5", mk(0, 0, 0, 0, 0, 0, 64'h200, 1, {32'h77, 64'h200}, 1));

    // PC wrap, then an asynchronous reset while a request is outstanding.
    run_vec("wrap.redir", mk(0, 0, 1, wrap_pc, 1, 0, 64'h200, 0, 0, 1));
    run_vec("wrap.req", mk(1, 32'h99, 0, 0, 1, 1, wrap_pc, 0, 0, 1));
    run_vec("wrap.hold", mk(0, 0, 0, 0, 1, 0, wrap_pc, 1, {32'h99, wrap_pc}, 1));
    run_vec("wrap.next", mk(0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 2));
    reset = 1'b0;
    #1;
    check_output("areset.ireq_valid", 96'(ireq_valid), 96'(0));
    check_output("areset.ireq_addr", 96'(ireq_addr), 96'(RESET_PC));
    check_output("areset.out_valid", 96'(out_valid), 96'(0));
    check_output("areset.fetch_count", 96'(fetch_count), 96'(0));

    // Randomized run against a transaction-level model of the fetch unit.
    begin
      bit          started, holding, stale;
      logic [63:0] m_pc, m_pend, m_cnt;
      logic [95:0] m_held;
      int          bus_cnt, bus_lat;
      logic        ok, rv, rdy, m_req;
      logic [31:0] data;
      logic [63:0] rpc;
      do_reset();
      started = 0; holding = 0; stale = 0;
      m_pc = RESET_PC; m_pend = 0; m_cnt = 0; m_held = 0;
      bus_cnt = 0; bus_lat = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        m_req = started && !holding;
        ok    = 1'b0;
        data  = $urandom;
        if (m_req) begin
          if (bus_cnt == 0) bus_lat = $urandom_range(0, 3);
          ok = (bus_cnt == bus_lat);
          if (ok) data = bus_word(m_pc);
        end
        rv  = ($urandom_range(0, 6) == 0);
        rpc = ($urandom_range(0, 9) == 0) ? wrap_pc - 64'(4 * $urandom_range(0, 2))
                                          : {32'h0, $urandom} & ~64'h3;
        rdy = ($urandom_range(0, 3) != 0);
        apply_stimulus(ok, data, rv, rpc, rdy);
        check_output("rnd.ireq_valid", 96'(ireq_valid), 96'(m_req));
        check_output("rnd.ireq_addr", 96'(ireq_addr), 96'(m_pc));
        check_output("rnd.out_valid", 96'(out_valid), 96'(holding && !rv));
        check_output("rnd.fetch_count", 96'(fetch_count), 96'(m_cnt));
        if (holding && !rv) check_output("rnd.out_data", out_data, m_held);

        if (!started) begin
          started = 1;
        end else if (holding) begin
          if (rv) begin
            m_pc = rpc; holding = 0;
          end else if (rdy) begin
            m_pc = m_pc + 64'd4; m_cnt = m_cnt + 64'd1; holding = 0;
          end
        end else if (stale) begin
          if (rv) m_pend = rpc;
          if (ok) begin
            m_pc = m_pend; stale = 0;
          end
        end else begin
          if (ok && rv) m_pc = rpc;
          else if (ok) begin
            m_held = {data, m_pc}; holding = 1;
          end else if (rv) begin
            m_pend = rpc; stale = 1;
          end
        end
        bus_cnt = (m_req && !ok) ? bus_cnt + 1 : 0;
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer at the front of the 5-stage pipeline. Owns the program counter, issues one instruction-bus request at a time, and hands each fetched word to decode as a `fetch_data_t` (`raw_instr`, `pc`) over a valid/ready handshake. Applies redirects from later stages (branch/jump resolution). A redirect that arrives while a bus request is in flight drains that request before refetching, because the bus cannot cancel a request.

## Interface
Parameters:
- `RESET_PC`, default 64'h8000_0000: PC fetched first after reset.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset. 0 resets the block immediately.
- `ireq_valid`, out, 1: instruction-bus request valid.
- `ireq_addr`, out, 64: request address. Stable while `ireq_valid`=1 until `iresp_data_ok`.
- `iresp_data_ok`, in, 1: the bus response for the outstanding request is valid this cycle.
- `iresp_data`, in, 32: instruction word. Sampled only when `iresp_data_ok`=1.
- `redirect_valid`, in, 1: one-cycle pulse; fetch must restart at `redirect_pc`.
- `redirect_pc`, in, 64: redirect target. Used as-is, no alignment check.
- `out_valid`, out, 1: `out_data` holds a valid fetched instruction.
- `out_data`, out, 96: `fetch_data_t` {`raw_instr`[95:64], `pc`[63:0]}.
- `out_ready`, in, 1: decode accepts `out_data` this cycle.
- `fetch_count`, out, 64: number of instructions transferred to decode since reset.

## Operation
State machine states: IDLE, REQ, DISCARD, HOLD.

Registers: `pc`, `pend_pc`, the `out_data` register, `fetch_count`.

Reset (while `reset`=0):
- state=IDLE, `pc`=RESET_PC, `pend_pc`=0, `out_data`=0, `fetch_count`=0.
- Outputs: `ireq_valid`=0, `ireq_addr`=RESET_PC, `out_valid`=0.

Output decode:
- `ireq_addr` = `pc` in every state.
- `ireq_valid` = 1 in REQ and DISCARD only.
- `out_valid` = (state==HOLD) & ~`redirect_valid`. This is combinational, so a redirect masks the transfer.
- fire = `out_valid` & `out_ready`.

Transitions (priority top-down within each state):
- IDLE: go to REQ unconditionally on the first edge after reset release.
- REQ, `iresp_data_ok` & `redirect_valid`: drop the data; `pc`<=`redirect_pc`; stay in REQ.
- REQ, `iresp_data_ok`: `out_data`<={`iresp_data`, `pc`}; go to HOLD.
- REQ, `redirect_valid` only: `pend_pc`<=`redirect_pc`; go to DISCARD.
- DISCARD: keeps requesting the old `pc`.
  - `redirect_valid`: `pend_pc`<=`redirect_pc`; the latest redirect wins.
  - `iresp_data_ok`: drop the data; `pc`<= (`redirect_valid` ? `redirect_pc` : `pend_pc`); go to REQ.
- HOLD, `redirect_valid`: `pc`<=`redirect_pc`; go to REQ; no transfer occurs.
- HOLD, fire: `pc`<=`pc`+4; `fetch_count`<=`fetch_count`+1; go to REQ.
- HOLD, otherwise: hold; `out_data` stays stable.

Arithmetic:
- `pc`+4 is 64-bit modulo: 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- `fetch_count` wraps modulo 2^64.

## Timing
- At most one bus request outstanding. `ireq_valid` never drops between request start and `iresp_data_ok`.
- A same-cycle `iresp_data_ok` (zero-wait bus) completes the request in that cycle.
- Latency, REQ entry with zero-wait bus → `out_valid` next cycle. Peak throughput is 1 instruction per 2 cycles.
- First `out_valid` is 2 cycles after reset release with a zero-wait bus.
- Redirect in HOLD or REQ: the refetch request for `redirect_pc` is driven next cycle. In REQ this holds only if `data_ok` coincides with the redirect; otherwise the block goes through DISCARD.
- Redirect during DISCARD or REQ without `data_ok`: the stale response is never presented to decode.
- Asserting `reset` mid-request abandons the request immediately. The bus owner must tolerate this.
- `out_ready` while `out_valid`=0 has no effect.

## Test plan
- Reset, zero-wait bus returning 32'h0000_0013, `out_ready`=1 → `out_valid` 2 cycles after release with `out_data`={32'h13, 64'h8000_0000}; the next request addresses 64'h8000_0004; `fetch_count`=1.
- Backpressure: `out_ready`=0 for 5 cycles in HOLD → `out_data` stable, `ireq_valid`=0, `pc` unchanged; raising `out_ready` → exactly one transfer.
- Redirect while waiting: bus has 3-cycle latency; `redirect_valid` with `redirect_pc`=64'h8000_0100 in REQ cycle 1 → `ireq_addr` stays at the old PC until `data_ok`; that data is dropped; the next request goes to 64'h8000_0100.
- Double redirect in DISCARD: targets 64'h100 then 64'h200 → refetch at 64'h200 only.
- Redirect in HOLD together with `out_ready`=1 → no transfer, `fetch_count` unchanged, next `ireq_addr`=`redirect_pc`.
- Wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, accept → next `ireq_addr`=0; assert `reset` during an outstanding request → all outputs at reset values in the same cycle.
